// File: rtl/gmii_rx_frame.sv
// gmii_rx_frame: strips preamble/SFD, checks and removes the CRC-32 FCS,
// streams payload with sof/eof/good markers and keeps saturating frame counters.
module gmii_rx_frame #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic [1:0]  rx_ctl,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_sof,
    output logic        out_eof,
    output logic        out_good,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_bad
);
    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    localparam logic [11:0] MIN_L   = 12'(MIN_LEN);
    localparam logic [11:0] MAX_L   = 12'(MAX_LEN);
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

    state_t      r_state;
    logic [7:0]  r_dl [5];
    logic [2:0]  r_held;
    logic [31:0] r_crc;
    logic [11:0] r_len;
    logic        r_err;
    logic        r_first;
    logic [15:0] r_frames_ok;
    logic [15:0] r_frames_bad;

    logic        w_dv;
    logic        w_er;
    logic        w_full;
    logic        w_good;
    logic [31:0] w_crc_next;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] x;
        x = c;
        for (int i = 0; i < 8; i++)
            x = (x >> 1) ^ ((x[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
        return x;
    endfunction

    assign w_dv       = rx_ctl[0];
    assign w_er       = rx_ctl[0] ^ rx_ctl[1];
    assign w_full     = r_held == 3'd5;
    assign w_crc_next = crc_byte(r_crc, rx_data);
    // CRC runs over the FCS too, so a clean frame leaves the fixed residue
    assign w_good     = (r_crc == RESIDUE) && !r_err && (r_len >= MIN_L) && (r_len <= MAX_L);
    assign frames_ok  = r_frames_ok;
    assign frames_bad = r_frames_bad;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_held       <= '0;
            r_crc        <= '1;
            r_len        <= '0;
            r_err        <= 1'b0;
            r_first      <= 1'b0;
            r_frames_ok  <= '0;
            r_frames_bad <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            out_sof      <= 1'b0;
            out_eof      <= 1'b0;
            out_good     <= 1'b0;
            for (int i = 0; i < 5; i++) r_dl[i] <= '0;
        end else begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_good  <= 1'b0;
            case (r_state)
                IDLE: if (w_dv) r_state <= (rx_data == 8'h55) ? PREAMBLE : DROP;
                PREAMBLE: begin
                    if (!w_dv) r_state <= IDLE;
                    else if (rx_data == 8'hD5) begin
                        r_state <= DATA;
                        r_crc   <= '1;
                        r_len   <= '0;
                        r_err   <= 1'b0;
                        r_held  <= '0;
                        r_first <= 1'b1;
                    end else if (rx_data != 8'h55) r_state <= DROP;
                end
                DATA: begin
                    if (w_dv) begin
                        r_dl[0] <= rx_data;
                        for (int i = 1; i < 5; i++) r_dl[i] <= r_dl[i-1];
                        r_crc <= w_crc_next;
                        r_len <= (r_len == 12'hFFF) ? r_len : r_len + 12'd1;
                        r_err <= r_err | w_er;
                        if (w_full) begin
                            out_data  <= r_dl[4];
                            out_valid <= 1'b1;
                            out_sof   <= r_first;
                            r_first   <= 1'b0;
                        end else r_held <= r_held + 3'd1;
                    end else begin
                        // the four bytes still held behind the last payload byte are the FCS
                        r_state <= IDLE;
                        if (w_full) begin
                            out_data  <= r_dl[4];
                            out_valid <= 1'b1;
                            out_sof   <= r_first;
                            out_eof   <= 1'b1;
                            out_good  <= w_good;
                        end
                        if (w_good) r_frames_ok <= r_frames_ok + 16'(r_frames_ok != 16'hFFFF);
                        else r_frames_bad <= r_frames_bad + 16'(r_frames_bad != 16'hFFFF);
                    end
                end
                DROP: if (!w_dv) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gmii_rx_frame.sv
// tb_gmii_rx_frame: directed frames with hand-computed expectations for gmii_rx_frame,
// run with MIN_LEN=13 so the 9-byte "123456789" frame is long enough.
module tb_gmii_rx_frame;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = '0;
    logic [1:0]  rx_ctl = '0;
    logic [7:0]  out_data;
    logic        out_valid, out_sof, out_eof, out_good;
    logic [15:0] frames_ok, frames_bad;

    gmii_rx_frame #(.MIN_LEN(13), .MAX_LEN(1518)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ctl(rx_ctl),
        .out_data(out_data), .out_valid(out_valid), .out_sof(out_sof),
        .out_eof(out_eof), .out_good(out_good),
        .frames_ok(frames_ok), .frames_bad(frames_bad)
    );

    always #4 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int exp_ok = 0, exp_bad = 0;
    logic [7:0] frm[$];
    logic [7:0] cap[$];
    int sof_idx[$], eof_idx[$];
    logic eof_good[$];
    int cyc = 0, first_cyc = -1, last_cyc = -1, stray = 0;

    // outputs are sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        cyc++;
        if (out_valid) begin
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            cap.push_back(out_data);
            if (out_sof) sof_idx.push_back(cap.size() - 1);
            if (out_eof) begin
                eof_idx.push_back(cap.size() - 1);
                eof_good.push_back(out_good);
            end
        end else if (out_sof || out_eof || out_good || out_data != 8'h00) stray++;
    end

    task automatic clr();
        cap.delete(); sof_idx.delete(); eof_idx.delete(); eof_good.delete();
        first_cyc = -1; last_cyc = -1;
    endtask

    task automatic drive(input logic dv, input logic er, input logic [7:0] d);
        rx_data = d;
        rx_ctl  = {dv ^ er, dv};
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int er_idx, input int gap);
        repeat (7) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        foreach (frm[i]) drive(1'b1, i == er_idx, frm[i]);
        repeat (gap) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic flush();
        repeat (3) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic mk_digits(input logic [7:0] last_fcs);
        frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                8'h26, 8'h39, 8'hF4, last_fcs};
    endtask

    task automatic mk_pattern(input int n);
        logic [31:0] c;
        frm.delete();
        for (int i = 0; i < n; i++) frm.push_back(8'(i * 7 + 3));
        c = 32'hFFFFFFFF;
        foreach (frm[i]) begin
            for (int b = 0; b < 8; b++) begin
                if (c[0] ^ frm[i][b]) c = (c >> 1) ^ 32'hEDB88320;
                else c = c >> 1;
            end
        end
        c = ~c;
        for (int k = 0; k < 4; k++) frm.push_back(c[8*k +: 8]);
    endtask

    function automatic int payload_errs(input int n);
        int e = 0;
        if (cap.size() != n) return -1;
        for (int i = 0; i < n; i++) if (cap[i] !== frm[i]) e++;
        return e;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'h55);
        n_chk++; if ({out_data, out_valid, out_sof, out_eof, out_good} !== 12'h0) $display("FAIL reset_out: got %h want 000", {out_data, out_valid, out_sof, out_eof, out_good}); else n_pass++;
        n_chk++; if ({frames_ok, frames_bad} !== 32'h0) $display("FAIL reset_cnt: got %h want 0", {frames_ok, frames_bad}); else n_pass++;
        reset = 1'b0;
        flush();
    endtask

    task automatic test_good_frame();
        clr(); mk_digits(8'hCB); send(-1, 1); flush(); exp_ok++;
        n_chk++; if (payload_errs(9) !== 0) $display("FAIL good_payload: got %0d errs (%0d bytes) want 0 errs (9 bytes)", payload_errs(9), cap.size()); else n_pass++;
        n_chk++; if ((sof_idx.size() == 1 && sof_idx[0] == 0) !== 1'b1) $display("FAIL good_sof: got %0d sofs want one on byte 0", sof_idx.size()); else n_pass++;
        n_chk++; if ((eof_idx.size() == 1 && eof_idx[0] == 8 && eof_good[0]) !== 1'b1) $display("FAIL good_eof: got %0d eofs want one good on byte 8", eof_idx.size()); else n_pass++;
        n_chk++; if (last_cyc - first_cyc + 1 !== 9) $display("FAIL good_gapless: got span %0d want 9", last_cyc - first_cyc + 1); else n_pass++;
        n_chk++; if (frames_ok !== 16'(exp_ok)) $display("FAIL good_cnt: got %0d want %0d", frames_ok, exp_ok); else n_pass++;
    endtask

    task automatic test_bad_fcs();
        clr(); mk_digits(8'hCC); send(-1, 1); flush(); exp_bad++;
        n_chk++; if (payload_errs(9) !== 0) $display("FAIL badfcs_payload: got %0d errs want 0", payload_errs(9)); else n_pass++;
        n_chk++; if ((eof_idx.size() == 1 && eof_idx[0] == 8 && !eof_good[0]) !== 1'b1) $display("FAIL badfcs_eof: got %0d eofs want one bad on byte 8", eof_idx.size()); else n_pass++;
        n_chk++; if ({frames_ok, frames_bad} !== {16'(exp_ok), 16'(exp_bad)}) $display("FAIL badfcs_cnt: got %0d/%0d want %0d/%0d", frames_ok, frames_bad, exp_ok, exp_bad); else n_pass++;
    endtask

    task automatic test_rx_er();
        clr(); mk_digits(8'hCB); send(4, 1); flush(); exp_bad++;
        n_chk++; if ((eof_idx.size() == 1 && !eof_good[0] && cap.size() == 9) !== 1'b1) $display("FAIL er_eof: got %0d eofs %0d bytes want one bad eof and 9 bytes", eof_idx.size(), cap.size()); else n_pass++;
        n_chk++; if (frames_bad !== 16'(exp_bad)) $display("FAIL er_cnt: got %0d want %0d", frames_bad, exp_bad); else n_pass++;
    endtask

    task automatic test_min_len();
        clr(); mk_pattern(8); send(-1, 1); flush(); exp_bad++;
        n_chk++; if ((payload_errs(8) == 0 && eof_idx.size() == 1 && !eof_good[0]) !== 1'b1) $display("FAIL short12_eof: got %0d bytes %0d eofs want 8 bytes one bad eof", cap.size(), eof_idx.size()); else n_pass++;
        clr(); mk_pattern(60); send(-1, 1); flush(); exp_ok++;
        n_chk++; if (payload_errs(60) !== 0) $display("FAIL len64_payload: got %0d errs (%0d bytes) want 0", payload_errs(60), cap.size()); else n_pass++;
        n_chk++; if ((eof_idx.size() == 1 && eof_idx[0] == 59 && eof_good[0]) !== 1'b1) $display("FAIL len64_eof: got %0d eofs want one good on byte 59", eof_idx.size()); else n_pass++;
        n_chk++; if ({frames_ok, frames_bad} !== {16'(exp_ok), 16'(exp_bad)}) $display("FAIL len_cnt: got %0d/%0d want %0d/%0d", frames_ok, frames_bad, exp_ok, exp_bad); else n_pass++;
    endtask

    task automatic test_runt();
        clr(); frm = '{8'h01, 8'h02, 8'h03, 8'h04}; send(-1, 1); flush(); exp_bad++;
        n_chk++; if (cap.size() !== 0) $display("FAIL runt_out: got %0d bytes want 0", cap.size()); else n_pass++;
        n_chk++; if (frames_bad !== 16'(exp_bad)) $display("FAIL runt_cnt: got %0d want %0d", frames_bad, exp_bad); else n_pass++;
    endtask

    task automatic test_oversize();
        clr(); mk_pattern(1515); send(-1, 1); flush(); exp_bad++;
        n_chk++; if (payload_errs(1515) !== 0) $display("FAIL over_payload: got %0d errs (%0d bytes) want 0", payload_errs(1515), cap.size()); else n_pass++;
        n_chk++; if ((eof_idx.size() == 1 && !eof_good[0]) !== 1'b1) $display("FAIL over_eof: got %0d eofs want one bad", eof_idx.size()); else n_pass++;
        clr(); mk_pattern(1514); send(-1, 1); flush(); exp_ok++;
        n_chk++; if ((payload_errs(1514) == 0 && eof_idx.size() == 1 && eof_good[0]) !== 1'b1) $display("FAIL max_eof: got %0d bytes %0d eofs want 1514 bytes one good eof", cap.size(), eof_idx.size()); else n_pass++;
        n_chk++; if ({frames_ok, frames_bad} !== {16'(exp_ok), 16'(exp_bad)}) $display("FAIL size_cnt: got %0d/%0d want %0d/%0d", frames_ok, frames_bad, exp_ok, exp_bad); else n_pass++;
    endtask

    task automatic test_drop();
        clr();
        repeat (3) drive(1'b0, 1'b1, 8'hAA);
        drive(1'b1, 1'b0, 8'h12);
        mk_digits(8'hCB); send(-1, 1); flush();
        n_chk++; if (cap.size() !== 0) $display("FAIL drop_out: got %0d bytes want 0", cap.size()); else n_pass++;
        n_chk++; if ({frames_ok, frames_bad} !== {16'(exp_ok), 16'(exp_bad)}) $display("FAIL drop_cnt: got %0d/%0d want %0d/%0d", frames_ok, frames_bad, exp_ok, exp_bad); else n_pass++;
    endtask

    task automatic test_reset_mid();
        clr(); mk_pattern(60);
        repeat (7) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, frm[i]);
        reset = 1'b1;
        drive(1'b1, 1'b0, frm[20]);
        n_chk++; if ({out_data, out_valid, out_sof, out_eof, out_good} !== 12'h0) $display("FAIL midrst_out: got %h want 000", {out_data, out_valid, out_sof, out_eof, out_good}); else n_pass++;
        n_chk++; if ({frames_ok, frames_bad} !== 32'h0) $display("FAIL midrst_cnt: got %h want 0", {frames_ok, frames_bad}); else n_pass++;
        reset = 1'b0; exp_ok = 0; exp_bad = 0;
        flush();
        n_chk++; if (eof_idx.size() !== 0) $display("FAIL midrst_eof: got %0d eofs want 0", eof_idx.size()); else n_pass++;
        clr(); mk_digits(8'hCB); send(-1, 1); flush(); exp_ok++;
        n_chk++; if ((payload_errs(9) == 0 && eof_idx.size() == 1 && eof_good[0] && frames_ok == 16'd1) !== 1'b1) $display("FAIL midrst_next: got %0d bytes %0d eofs ok=%0d want 9 bytes one good eof ok=1", cap.size(), eof_idx.size(), frames_ok); else n_pass++;
    endtask

    task automatic test_back_to_back();
        clr(); mk_digits(8'hCB);
        send(-1, 1); send(-1, 1); flush(); exp_ok += 2;
        n_chk++; if ((cap.size() == 18 && sof_idx.size() == 2 && sof_idx[1] == 9) !== 1'b1) $display("FAIL b2b_out: got %0d bytes %0d sofs want 18 bytes 2 sofs", cap.size(), sof_idx.size()); else n_pass++;
        n_chk++; if ((eof_idx.size() == 2 && eof_good[0] && eof_good[1]) !== 1'b1) $display("FAIL b2b_eof: got %0d eofs want 2 good", eof_idx.size()); else n_pass++;
        n_chk++; if (frames_ok !== 16'(exp_ok)) $display("FAIL b2b_cnt: got %0d want %0d", frames_ok, exp_ok); else n_pass++;
    endtask

    task automatic test_saturation();
        force dut.r_frames_bad = 16'hFFFE;
        drive(1'b0, 1'b0, 8'h00);
        release dut.r_frames_bad;
        frm.delete();
        send(-1, 1); flush();
        n_chk++; if (frames_bad !== 16'hFFFF) $display("FAIL sat_reach: got %h want ffff", frames_bad); else n_pass++;
        send(-1, 1); flush();
        n_chk++; if (frames_bad !== 16'hFFFF) $display("FAIL sat_hold: got %h want ffff", frames_bad); else n_pass++;
        n_chk++; if (frames_ok !== 16'(exp_ok)) $display("FAIL sat_ok: got %0d want %0d", frames_ok, exp_ok); else n_pass++;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_good_frame();
        test_bad_fcs();
        test_rx_er();
        test_min_len();
        test_runt();
        test_oversize();
        test_drop();
        test_reset_mid();
        test_back_to_back();
        test_saturation();
        n_chk++; if (stray !== 0) $display("FAIL idle_outputs: got %0d stray cycles want 0", stray); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
